// File: rtl/msk_skinny_pkg.sv
// Shared definitions for the masked SKINNY-128-128 controllers: FSM states,
// round geometry and the per-cycle share-mux / S-box stage schedule.
package msk_skinny_pkg;

  localparam int unsigned NR  = 40;
  localparam int unsigned CPR = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KEYFWD,
    ST_DECRYPT,
    ST_DONE
  } state_e;

  // mux_sel bit order {1a1,2a1,1b1,2b1,1x1,2x1,1a2,2a2,1b2,2b2,1x2,2x2}
  localparam logic [11:0] MUX_C0 = 12'h200;
  localparam logic [11:0] MUX_C1 = 12'h908;
  localparam logic [11:0] MUX_C2 = 12'h7A4;
  localparam logic [11:0] MUX_C3 = 12'hC5E;
  localparam logic [11:0] MUX_C4 = 12'h0F1;
  localparam logic [11:0] MUX_C5 = 12'h003;

  // S-box pipeline stages 2..5 map to bits 0..3
  localparam logic [3:0] STG_C1 = 4'b0001;
  localparam logic [3:0] STG_C2 = 4'b0010;
  localparam logic [3:0] STG_C3 = 4'b0100;
  localparam logic [3:0] STG_C4 = 4'b1000;

endpackage

// File: rtl/msk_round_ctr.sv
// Round and intra-round cycle counters for the masked SKINNY controllers.
// Load has priority over decrement and step; the cycle counter wraps at CPR-1.
module msk_round_ctr
  import msk_skinny_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [5:0] load_val,
  input  logic       dec,
  input  logic       step,
  output logic [5:0] round_cnt,
  output logic [2:0] cycle_cnt,
  output logic       last_cycle,
  output logic       last_round
);

  assign last_cycle = (cycle_cnt == 3'(CPR - 1));
  assign last_round = (round_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      round_cnt <= '0;
      cycle_cnt <= '0;
    end else if (load) begin
      round_cnt <= load_val;
      cycle_cnt <= '0;
    end else begin
      if (dec)
        round_cnt <= round_cnt - 6'd1;
      if (step)
        cycle_cnt <= last_cycle ? '0 : cycle_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/msk_fsmbt_dec.sv
// Control FSM for masked SKINNY-128-128 decryption with Borrowed-Time hardening:
// key fast-forward, 40 inverse rounds of 6 cycles, then a one-cycle done pulse.
module msk_fsmbt_dec
  import msk_skinny_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        sel_load,
  output logic        clear,
  output logic        key_fwd,
  output logic        key_inv,
  output logic        sel_lin_inv,
  output logic [5:0]  rc_idx,
  output logic [11:0] mux_sel,
  output logic [3:0]  stage_en,
  output logic        en_glitch
);

  state_e     state, next_state;
  logic       ctr_load, ctr_dec, ctr_step;
  logic [5:0] ctr_load_val;
  logic [5:0] round_cnt;
  logic [2:0] cycle_cnt;
  logic       last_cycle, last_round;

  msk_round_ctr u_ctr (
    .clk        (clk),
    .reset      (reset),
    .load       (ctr_load),
    .load_val   (ctr_load_val),
    .dec        (ctr_dec),
    .step       (ctr_step),
    .round_cnt  (round_cnt),
    .cycle_cnt  (cycle_cnt),
    .last_cycle (last_cycle),
    .last_round (last_round)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  assign busy = (state != ST_IDLE);

  always_comb begin
    next_state   = state;
    done         = 1'b0;
    sel_load     = 1'b0;
    clear        = 1'b0;
    key_fwd      = 1'b0;
    key_inv      = 1'b0;
    sel_lin_inv  = 1'b0;
    rc_idx       = '0;
    mux_sel      = '0;
    stage_en     = '0;
    en_glitch    = 1'b0;
    ctr_load     = 1'b0;
    ctr_load_val = '0;
    ctr_dec      = 1'b0;
    ctr_step     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start)
          next_state = ST_LOAD;
      end
      ST_LOAD: begin
        sel_load     = 1'b1;
        clear        = 1'b1;
        ctr_load     = 1'b1;
        ctr_load_val = 6'(NR - 2);
        next_state   = ST_KEYFWD;
      end
      ST_KEYFWD: begin
        key_fwd = 1'b1;
        if (last_round) begin
          ctr_load     = 1'b1;
          ctr_load_val = 6'(NR - 1);
          next_state   = ST_DECRYPT;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      ST_DECRYPT: begin
        ctr_step = 1'b1;
        rc_idx   = round_cnt;
        case (cycle_cnt)
          3'd0: begin
            sel_lin_inv = 1'b1;
            mux_sel     = MUX_C0;
          end
          3'd1: begin
            mux_sel  = MUX_C1;
            stage_en = STG_C1;
          end
          3'd2: begin
            mux_sel  = MUX_C2;
            stage_en = STG_C2;
          end
          3'd3: begin
            mux_sel  = MUX_C3;
            stage_en = STG_C3;
          end
          3'd4: begin
            mux_sel   = MUX_C4;
            stage_en  = STG_C4;
            en_glitch = 1'b1;
          end
          3'd5: begin
            mux_sel = MUX_C5;
            key_inv = !last_round;
            // Final round reloads zero so the counters rest cleanly after DONE.
            if (last_round) begin
              ctr_load   = 1'b1;
              next_state = ST_DONE;
            end else begin
              ctr_dec = 1'b1;
            end
          end
          default: rc_idx = '0;
        endcase
      end
      ST_DONE: begin
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_msk_fsmbt_dec.sv
// Self-checking bench for msk_fsmbt_dec against a cycle-offset model of the schedule.
module tb_msk_fsmbt_dec;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, sel_load, clear, key_fwd, key_inv, sel_lin_inv, en_glitch;
  logic [5:0]  rc_idx;
  logic [11:0] mux_sel;
  logic [3:0]  stage_en;

  msk_fsmbt_dec dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .sel_load    (sel_load),
    .clear       (clear),
    .key_fwd     (key_fwd),
    .key_inv     (key_inv),
    .sel_lin_inv (sel_lin_inv),
    .rc_idx      (rc_idx),
    .mux_sel     (mux_sel),
    .stage_en    (stage_en),
    .en_glitch   (en_glitch)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: t = cycles since the start edge (0 = idle, 1 = LOAD ... 281 = DONE)
  int t = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset)         t <= 0;
    else if (t == 0)    t <= start ? 1 : 0;
    else if (t == 281)  t <= 0;
    else                t <= t + 1;
  end

  logic [11:0] mux_tab [6];
  int kf_cnt = 0, ki_cnt = 0, eg_cnt = 0;
  int dut_dones = 0, model_dones = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic       e_load, e_kf, e_dec, e_done, e_ki, e_lin, e_eg;
    logic [5:0] e_rc;
    logic [11:0] e_mux;
    logic [3:0] e_stg;
    int k, rnd, c;
    e_load = (t == 1);
    e_kf   = (t >= 2 && t <= 40);
    e_dec  = (t >= 41 && t <= 280);
    e_done = (t == 281);
    k   = t - 41;
    rnd = 39 - k / 6;
    c   = k % 6;
    e_rc  = e_dec ? 6'(rnd) : 6'd0;
    e_mux = e_dec ? mux_tab[c] : 12'h000;
    e_stg = (e_dec && c >= 1 && c <= 4) ? 4'(1 << (c - 1)) : 4'd0;
    e_lin = e_dec && c == 0;
    e_eg  = e_dec && c == 4;
    e_ki  = e_dec && c == 5 && rnd != 0;

    check("busy", 32'(busy), 32'(t != 0));
    check("done", 32'(done), 32'(e_done));
    check("sel_load", 32'(sel_load), 32'(e_load));
    check("clear", 32'(clear), 32'(e_load));
    check("key_fwd", 32'(key_fwd), 32'(e_kf));
    check("key_inv", 32'(key_inv), 32'(e_ki));
    check("sel_lin_inv", 32'(sel_lin_inv), 32'(e_lin));
    check("rc_idx", 32'(rc_idx), 32'(e_rc));
    check("mux_sel", 32'(mux_sel), 32'(e_mux));
    check("stage_en", 32'(stage_en), 32'(e_stg));
    check("en_glitch", 32'(en_glitch), 32'(e_eg));

    if (t == 1) begin
      kf_cnt = 0; ki_cnt = 0; eg_cnt = 0;
    end
    kf_cnt += int'(key_fwd);
    ki_cnt += int'(key_inv);
    eg_cnt += int'(en_glitch);
    dut_dones += int'(done);
    model_dones += int'(e_done);
    if (e_done) begin
      check("key_fwd_count", 32'(kf_cnt), 32'd39);
      check("key_inv_count", 32'(ki_cnt), 32'd39);
      check("en_glitch_count", 32'(eg_cnt), 32'd40);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    mux_tab[0] = 12'h200; mux_tab[1] = 12'h908; mux_tab[2] = 12'h7A4;
    mux_tab[3] = 12'hC5E; mux_tab[4] = 12'h0F1; mux_tab[5] = 12'h003;

    // reset state, start ignored while in reset
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    reset = 1'b1;
    repeat (2) tick();

    // single clean operation
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (300) tick();

    // random start noise across all states
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 7) == 0);
      tick();
    end
    start = 1'b0;
    repeat (300) tick();

    // start held high: back-to-back operations
    start = 1'b1;
    repeat (700) tick();
    start = 1'b0;
    repeat (300) tick();

    // asynchronous reset in the middle of KEYFWD with start held
    start = 1'b1;
    tick();
    for (int i = 0; i < 100 && t != 20; i++) tick();
    check("in_keyfwd_before_rst", 32'(key_fwd), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_busy_immediate", 32'(busy), 32'd0);
    check("rst_keyfwd_immediate", 32'(key_fwd), 32'd0);
    check_outputs();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("load_after_rst", 32'(sel_load), 32'd1);
    start = 1'b0;
    repeat (300) tick();

    check("done_per_load", 32'(dut_dones), 32'(model_dones));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
